cam_ctrl: RTL and testbench

//  Initiator/sequencer for the 14-entry 8-bit cam: the request-side end of its write/enable/search port.

---
 rtl/cam_pkg.sv | 29 ++
 rtl/cam.sv | 52 +++++
 rtl/cam_free_enc.sv | 27 ++
 rtl/cam_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared encodings and sizing for the cam request sequencer and its cam.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cam_pkg;

  localparam int          NB_MEM      = 14;     // cam entries
  localparam int          SIZE_ADDR   = 4;      // index bits actually used
  localparam int          ADDR_W      = 5;      // cam address / response index width
  localparam int          KEY_W       = 8;      // key width
  localparam int          CNT_W       = 5;      // occupancy counter width (0..NB_MEM)
  localparam logic [7:0]  INVALID_KEY = 8'hFF;  // marks an empty slot

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_FLUSH  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_RESULT = 3'd3,
    ST_WRITE  = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

endpackage

// File: rtl/cam.sv
// Small content-addressable memory: write port plus registered search result.
// Latency: search result (found/out) valid the cycle after enable; write lands at the clock edge.
// Backpressure: none; contents are never reset and must be initialised by the requester.
//   clk    in  1            clock
//   write  in  1            store data at addr
//   enable in  1            search for data
//   addr   in  SIZE_ADDR+1  write address (writes at or beyond NB_MEM are ignored)
//   data   in  8            write data / search key
//   out    out SIZE_ADDR+1  lowest matching index (registered)
//   found  out 1            any entry matched (registered)
module cam #(
  parameter int NB_MEM    = 14,
  parameter int SIZE_ADDR = 4
) (
  input  logic                 clk,
  input  logic                 write,
  input  logic                 enable,
  input  logic [SIZE_ADDR:0]   addr,
  input  logic [7:0]           data,
  output logic [SIZE_ADDR:0]   out,
  output logic                 found
);

  localparam int AW = SIZE_ADDR + 1;

  logic [7:0]    r_mem [NB_MEM];
  logic          w_hit;
  logic [AW-1:0] w_idx;

  // Lowest matching entry wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NB_MEM - 1; i >= 0; i--) begin
      if (r_mem[i] == data) begin
        w_hit = 1'b1;
        w_idx = AW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write && (int'(addr) < NB_MEM)) begin
      r_mem[addr[SIZE_ADDR-1:0]] <= data;
    end
    if (enable) begin
      found <= w_hit;
      out   <= w_idx;
    end
  end

endmodule

// File: rtl/cam_free_enc.sv
// Lowest-free-slot finder over the occupancy map.
// Latency: combinational.
// Backpressure: none.
//   valid_map in  NB_MEM     occupancy bit per slot
//   free_idx  out SIZE_ADDR  lowest slot whose bit is 0 (0 when full)
//   full      out 1          every slot occupied
module cam_free_enc
  import cam_pkg::*;
(
  input  logic [NB_MEM-1:0]    valid_map,
  output logic [SIZE_ADDR-1:0] free_idx,
  output logic                 full
);

  // Scan from the top down so the last hit written is the lowest free slot.
  always_comb begin
    free_idx = '0;
    full     = 1'b1;
    for (int i = NB_MEM - 1; i >= 0; i--) begin
      if (!valid_map[i]) begin
        free_idx = SIZE_ADDR'(i);
        full     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// Request sequencer for the cam: turns LOOKUP/INSERT/DELETE/FLUSH requests into cam search/write cycles.
// Latency: lookup rsp 2 cycles after accept, writing ops 3, reserved key 1, flush after the full re-init sweep.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready/op/key     request channel
//   rsp_valid/rsp_ready/hit/err/idx response channel
//   count                          occupied slots
//   cam_write/enable/addr/data     cam drive side; cam_out/cam_found cam result side
module cam_ctrl
  import cam_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [KEY_W-1:0]  req_key,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rsp_idx,
  output logic [CNT_W-1:0]  count,
  output logic              cam_write,
  output logic              cam_enable,
  output logic [ADDR_W-1:0] cam_addr,
  output logic [KEY_W-1:0]  cam_data,
  input  logic [ADDR_W-1:0] cam_out,
  input  logic              cam_found
);

  // All outputs are registered from the next-state decode so they are 0 while
  // reset is held and change only on clock edges.
  state_e              r_state,     w_state;
  op_e                 r_op,        w_op;
  logic [KEY_W-1:0]    r_key,       w_key;
  logic                r_bad_key,   w_bad_key;
  logic                r_flush,     w_flush;
  logic [CNT_W-1:0]    r_init_cnt,  w_init_cnt;
  logic [NB_MEM-1:0]   r_valid,     w_valid;
  logic [CNT_W-1:0]    r_count,     w_count;
  logic                r_req_ready, w_req_ready;
  logic                r_rsp_valid, w_rsp_valid;
  logic                r_rsp_hit,   w_rsp_hit;
  logic                r_rsp_err,   w_rsp_err;
  logic [ADDR_W-1:0]   r_rsp_idx,   w_rsp_idx;
  logic                r_cam_write, w_cam_write;
  logic                r_cam_en,    w_cam_en;
  logic [ADDR_W-1:0]   r_cam_addr,  w_cam_addr;
  logic [KEY_W-1:0]    r_cam_data,  w_cam_data;

  logic [SIZE_ADDR-1:0] w_free_idx;
  logic                 w_full;
  logic [ADDR_W-1:0]    w_hit_idx;
  logic                 w_unused;

  // Upper cam index bit is always 0 for a 14-entry cam.
  assign w_unused  = cam_out[ADDR_W-1];
  assign w_hit_idx = {1'b0, cam_out[SIZE_ADDR-1:0]};

  cam_free_enc u_free_enc (
    .valid_map (r_valid),
    .free_idx  (w_free_idx),
    .full      (w_full)
  );

  always_comb begin
    w_state     = r_state;
    w_op        = r_op;
    w_key       = r_key;
    w_bad_key   = r_bad_key;
    w_flush     = r_flush;
    w_init_cnt  = r_init_cnt;
    w_valid     = r_valid;
    w_count     = r_count;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_hit   = r_rsp_hit;
    w_rsp_err   = r_rsp_err;
    w_rsp_idx   = r_rsp_idx;
    w_cam_write = 1'b0;
    w_cam_en    = 1'b0;
    w_cam_addr  = r_cam_addr;
    w_cam_data  = r_cam_data;

    case (r_state)
      ST_INIT: begin
        // r_init_cnt is the next address to clear; the sweep ends once all are issued.
        if (r_init_cnt == CNT_W'(NB_MEM)) begin
          if (r_flush) begin
            w_state     = ST_RESP;
            w_flush     = 1'b0;
            w_rsp_valid = 1'b1;
            w_rsp_hit   = 1'b0;
            w_rsp_err   = 1'b0;
            w_rsp_idx   = '0;
          end else begin
            w_state     = ST_IDLE;
            w_req_ready = 1'b1;
          end
        end else begin
          w_cam_write = 1'b1;
          w_cam_addr  = r_init_cnt;
          w_cam_data  = INVALID_KEY;
          w_init_cnt  = r_init_cnt + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid && r_req_ready) begin
          w_req_ready = 1'b0;
          w_op        = op_e'(req_op);
          w_key       = req_key;
          w_bad_key   = 1'b0;
          if (req_op == OP_FLUSH) begin
            w_state    = ST_INIT;
            w_init_cnt = '0;
            w_valid    = '0;
            w_count    = '0;
            w_flush    = 1'b1;
          end else if (req_key == INVALID_KEY) begin
            // Pass through RESULT without touching the cam so the error
            // response appears one cycle after accept.
            w_state   = ST_RESULT;
            w_bad_key = 1'b1;
          end else begin
            w_state    = ST_SEARCH;
            w_cam_en   = 1'b1;
            w_cam_data = req_key;
          end
        end
      end

      ST_SEARCH: begin
        w_state = ST_RESULT;
      end

      ST_RESULT: begin
        w_state     = ST_RESP;
        w_rsp_valid = 1'b1;
        w_rsp_hit   = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_idx   = '0;
        if (r_bad_key) begin
          w_rsp_err = 1'b1;
        end else begin
          case (r_op)
            OP_LOOKUP: begin
              if (cam_found) begin
                w_rsp_hit = 1'b1;
                w_rsp_idx = w_hit_idx;
              end
            end
            OP_INSERT: begin
              if (cam_found) begin
                w_rsp_hit = 1'b1;
                w_rsp_idx = w_hit_idx;
              end else if (w_full) begin
                w_rsp_err = 1'b1;
              end else begin
                w_state     = ST_WRITE;
                w_rsp_valid = 1'b0;
                w_cam_write = 1'b1;
                w_cam_addr  = {1'b0, w_free_idx};
                w_cam_data  = r_key;
                w_rsp_idx   = {1'b0, w_free_idx};
              end
            end
            OP_DELETE: begin
              if (cam_found) begin
                w_state     = ST_WRITE;
                w_rsp_valid = 1'b0;
                w_rsp_hit   = 1'b1;
                w_rsp_idx   = w_hit_idx;
                w_cam_write = 1'b1;
                w_cam_addr  = w_hit_idx;
                w_cam_data  = INVALID_KEY;
              end
            end
            default: ;
          endcase
        end
      end

      ST_WRITE: begin
        // The slot being written is still held on r_cam_addr.
        w_state     = ST_RESP;
        w_rsp_valid = 1'b1;
        if (r_op == OP_INSERT) begin
          w_valid[r_cam_addr[SIZE_ADDR-1:0]] = 1'b1;
          w_count = r_count + CNT_W'(1);
        end else begin
          w_valid[r_cam_addr[SIZE_ADDR-1:0]] = 1'b0;
          if (r_count != '0) begin
            w_count = r_count - CNT_W'(1);
          end
        end
      end

      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = ST_IDLE;
          w_req_ready = 1'b1;
        end
      end

      default: begin
        w_state    = ST_INIT;
        w_init_cnt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_op        <= OP_LOOKUP;
      r_key       <= '0;
      r_bad_key   <= 1'b0;
      r_flush     <= 1'b0;
      r_init_cnt  <= '0;
      r_valid     <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_idx   <= '0;
      r_cam_write <= 1'b0;
      r_cam_en    <= 1'b0;
      r_cam_addr  <= '0;
      r_cam_data  <= '0;
    end else begin
      r_state     <= w_state;
      r_op        <= w_op;
      r_key       <= w_key;
      r_bad_key   <= w_bad_key;
      r_flush     <= w_flush;
      r_init_cnt  <= w_init_cnt;
      r_valid     <= w_valid;
      r_count     <= w_count;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_hit   <= w_rsp_hit;
      r_rsp_err   <= w_rsp_err;
      r_rsp_idx   <= w_rsp_idx;
      r_cam_write <= w_cam_write;
      r_cam_en    <= w_cam_en;
      r_cam_addr  <= w_cam_addr;
      r_cam_data  <= w_cam_data;
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_hit    = r_rsp_hit;
  assign rsp_err    = r_rsp_err;
  assign rsp_idx    = r_rsp_idx;
  assign count      = r_count;
  assign cam_write  = r_cam_write;
  assign cam_enable = r_cam_en;
  assign cam_addr   = r_cam_addr;
  assign cam_data   = r_cam_data;

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl driving the real cam.
// Latency: n/a.
// Backpressure: exercises held responses and reset during a write.
module tb_cam_ctrl;
  import cam_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_key = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_hit;
  logic       rsp_err;
  logic [4:0] rsp_idx;
  logic [4:0] count;
  logic       cam_write;
  logic       cam_enable;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic [4:0] cam_out;
  logic       cam_found;

  always #5 clk = ~clk;

  cam_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_key    (req_key),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hit    (rsp_hit),
    .rsp_err    (rsp_err),
    .rsp_idx    (rsp_idx),
    .count      (count),
    .cam_write  (cam_write),
    .cam_enable (cam_enable),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_out    (cam_out),
    .cam_found  (cam_found)
  );

  cam #(.NB_MEM(NB_MEM), .SIZE_ADDR(SIZE_ADDR)) u_cam (
    .clk    (clk),
    .write  (cam_write),
    .enable (cam_enable),
    .addr   (cam_addr),
    .data   (cam_data),
    .out    (cam_out),
    .found  (cam_found)
  );

  // cam port monitor, sampled mid-cycle
  int         n_wr = 0;
  int         n_en = 0;
  int         n_both = 0;
  int         n_rsp = 0;
  logic [4:0] l_wr_addr = '0;
  logic [7:0] l_wr_data = '0;
  logic [4:0] wr_addr_a [0:63];
  logic [7:0] wr_data_a [0:63];

  always @(negedge clk) begin
    if (cam_write === 1'b1) begin
      wr_addr_a[n_wr % 64] <= cam_addr;
      wr_data_a[n_wr % 64] <= cam_data;
      l_wr_addr <= cam_addr;
      l_wr_data <= cam_data;
      n_wr      <= n_wr + 1;
    end
    if (cam_enable === 1'b1) n_en <= n_en + 1;
    if (cam_write === 1'b1 && cam_enable === 1'b1) n_both <= n_both + 1;
    if (rsp_valid === 1'b1) n_rsp <= n_rsp + 1;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic g_hit, g_err, g_got;
  logic [4:0] g_idx;
  int g_lat;

  // Issue one request and wait for its response; leaves the response pending.
  task automatic send_req(input logic [1:0] op, input logic [7:0] key);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    g_got     = 1'b0;
    g_lat     = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        g_got = 1'b1;
        g_lat = i;
        break;
      end
    end
    check("rsp_arrived", g_got, 1);
    g_hit = rsp_hit;
    g_err = rsp_err;
    g_idx = rsp_idx;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int   w0, e0, r0;
  logic seen, prev_wr;
  logic [4:0] prev_addr;

  initial begin
    // ---- 1: reset state and init sweep ----
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cam_write", cam_write, 0);
    check("rst_cam_enable", cam_enable, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    prev_wr = 1'b0;
    prev_addr = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      prev_wr = cam_write;
      prev_addr = cam_addr;
    end
    check("init_done", seen, 1);
    check("init_last_write_before_ready", prev_wr, 1);
    check("init_last_addr", prev_addr, 13);
    check("init_write_count", n_wr, 14);
    for (int i = 0; i < 14; i++) begin
      check("init_addr", wr_addr_a[i], i);
      check("init_data", wr_data_a[i], 8'hFF);
    end
    check("init_count", count, 0);

    // ---- 2: insert, then duplicate insert ----
    w0 = n_wr;
    send_req(OP_INSERT, 8'h3C);
    check("ins3c_hit", g_hit, 0);
    check("ins3c_err", g_err, 0);
    check("ins3c_idx", g_idx, 0);
    check("ins3c_lat", g_lat, 4);
    check("ins3c_count", count, 1);
    check("ins3c_writes", n_wr - w0, 1);
    check("ins3c_wr_addr", l_wr_addr, 0);
    check("ins3c_wr_data", l_wr_data, 8'h3C);
    ack_rsp();
    w0 = n_wr;
    send_req(OP_INSERT, 8'h3C);
    check("dup_hit", g_hit, 1);
    check("dup_idx", g_idx, 0);
    check("dup_lat", g_lat, 3);
    check("dup_writes", n_wr - w0, 0);
    check("dup_count", count, 1);
    ack_rsp();

    // ---- 3: fill, overflow, lookup ----
    for (int i = 0; i < 13; i++) begin
      send_req(OP_INSERT, 8'(8'h10 + i));
      check("fill_hit", g_hit, 0);
      check("fill_idx", g_idx, i + 1);
      ack_rsp();
    end
    check("full_count", count, 14);
    w0 = n_wr;
    send_req(OP_INSERT, 8'h55);
    check("ovf_err", g_err, 1);
    check("ovf_hit", g_hit, 0);
    check("ovf_idx", g_idx, 0);
    check("ovf_writes", n_wr - w0, 0);
    check("ovf_count", count, 14);
    ack_rsp();
    send_req(OP_LOOKUP, 8'h13);
    check("lk5_hit", g_hit, 1);
    check("lk5_idx", g_idx, 4);
    check("lk5_err", g_err, 0);
    check("lk5_lat", g_lat, 3);
    ack_rsp();

    // ---- 4: delete and reuse slot 0 ----
    w0 = n_wr;
    send_req(OP_DELETE, 8'h3C);
    check("del_hit", g_hit, 1);
    check("del_idx", g_idx, 0);
    check("del_lat", g_lat, 4);
    check("del_writes", n_wr - w0, 1);
    check("del_wr_addr", l_wr_addr, 0);
    check("del_wr_data", l_wr_data, 8'hFF);
    check("del_count", count, 13);
    ack_rsp();
    send_req(OP_LOOKUP, 8'h3C);
    check("lk3c_hit", g_hit, 0);
    check("lk3c_idx", g_idx, 0);
    ack_rsp();
    send_req(OP_INSERT, 8'h77);
    check("ins77_hit", g_hit, 0);
    check("ins77_idx", g_idx, 0);
    check("ins77_count", count, 14);
    ack_rsp();

    // ---- 5: reserved key, flush ----
    w0 = n_wr;
    e0 = n_en;
    send_req(OP_LOOKUP, 8'hFF);
    check("rsv_err", g_err, 1);
    check("rsv_hit", g_hit, 0);
    check("rsv_lat", g_lat, 2);
    check("rsv_no_enable", n_en - e0, 0);
    check("rsv_no_write", n_wr - w0, 0);
    ack_rsp();
    w0 = n_wr;
    send_req(OP_FLUSH, 8'h00);
    check("flush_hit", g_hit, 0);
    check("flush_err", g_err, 0);
    check("flush_writes", n_wr - w0, 14);
    check("flush_count", count, 0);
    ack_rsp();
    send_req(OP_LOOKUP, 8'h77);
    check("lk77_hit", g_hit, 0);
    check("lk77_idx", g_idx, 0);
    ack_rsp();

    // ---- 6: held response, then reset during WRITE ----
    send_req(OP_INSERT, 8'h42);
    check("ins42_idx", g_idx, 0);
    ack_rsp();
    send_req(OP_LOOKUP, 8'h42);
    check("hold_hit0", g_hit, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_hit", rsp_hit, 1);
      check("hold_idx", rsp_idx, 0);
      check("hold_err", rsp_err, 0);
      check("hold_req_ready", req_ready, 0);
    end
    ack_rsp();

    seen = 1'b0;
    for (int i = 0; i < 100 && req_ready !== 1'b1; i++) @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_INSERT;
    req_key   = 8'h50;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (cam_write === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_write_seen", seen, 1);
    r0 = n_rsp;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cam_write", cam_write, 0);
    check("mid_rst_cam_addr", cam_addr, 0);
    check("mid_rst_cam_data", cam_data, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = n_wr;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("reinit_done", seen, 1);
    check("reinit_writes", n_wr - w0, 14);
    check("reinit_no_rsp", n_rsp - r0, 0);
    check("reinit_count", count, 0);
    send_req(OP_LOOKUP, 8'h42);
    check("post_rst_hit", g_hit, 0);
    ack_rsp();

    check("never_write_and_enable", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
